// File: rtl/carryskip_pkg.sv
// rtl/carryskip_pkg.sv - op encoding and pipeline stage control record for the carry-skip add/accumulate core
// Contents:
//   op_e        : 2-bit operation code (ADD, SUB, ACC, CLR)
//   stage_ctl_t : width-independent part of a stage register (carry, msb_cin, op, valid)
//   op_uses_acc : true for ops that read or write the accumulator
package carryskip_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    // The WIDTH-sized fields (sum, a, b) depend on the core parameter, so the
    // top wraps this record into its full stage register type.
    typedef struct packed {
        logic carry;    // carry into the next unprocessed bit
        logic msb_cin;  // carry into the MSB, valid once the last stage ran
        op_e  op;
        logic valid;
    } stage_ctl_t;

    function automatic logic op_uses_acc(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/carryskip_block.sv
// rtl/carryskip_block.sv - one BLOCK-bit ripple adder segment with carry-skip bypass
// Ports:
//   i_a, i_b : BLOCK-bit operand slices
//   i_cin    : carry into the block
//   o_sum    : BLOCK-bit sum slice
//   o_cout   : block carry out (bypassed straight from i_cin when every bit propagates)
module carryskip_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] i_a,
    input  logic [BLOCK-1:0] i_b,
    input  logic             i_cin,
    output logic [BLOCK-1:0] o_sum,
    output logic             o_cout
);

    logic [BLOCK-1:0] w_p;
    logic [BLOCK:0]   w_c;

    always_comb begin
        w_p    = i_a ^ i_b;
        w_c    = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < BLOCK; i++) begin
            w_c[i+1] = (i_a[i] & i_b[i]) | (w_p[i] & w_c[i]);
        end
    end

    assign o_sum  = w_p ^ w_c[BLOCK-1:0];
    // Skip mux: a fully propagating block forwards its carry-in without
    // waiting for the internal ripple.
    assign o_cout = (&w_p) ? i_cin : w_c[BLOCK];

endmodule

// File: rtl/carryskip_pipe_addacc.sv
// rtl/carryskip_pipe_addacc.sv - pipelined carry-skip adder with subtract, accumulate and clear
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready          : operation handshake; in_ready depends on in_op
//   in_op, in_a, in_b, in_cin  : operation and operands
//   out_valid/out_ready        : result handshake
//   out_sum, out_cout          : result and carry out (SUB: 1 = no borrow)
//   out_ovf, out_zero          : signed overflow and zero flags
// WIDTH must be a multiple of BLOCK*BPS; latency is WIDTH/(BLOCK*BPS) cycles.
module carryskip_pipe_addacc
    import carryskip_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4,
    parameter int BPS   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int SW     = BLOCK * BPS;
    localparam int STAGES = WIDTH / SW;

    typedef struct packed {
        logic [WIDTH-1:0] sum;  // bits below the current stage boundary are final
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        stage_ctl_t       ctl;
    } stage_t;

    stage_t           r_stg [STAGES];
    stage_t           w_nxt [STAGES];
    stage_t           w_opnd;
    logic [WIDTH-1:0] r_acc;
    logic             r_acc_busy;
    logic             w_adv;
    logic             w_accept;
    logic             w_out_hs;
    op_e              w_op;

    assign w_op     = op_e'(in_op);
    // Stall-all: every stage moves only when the output slot is free or draining.
    assign w_adv    = !r_stg[STAGES-1].ctl.valid || out_ready;
    // Only one accumulator op may be in flight; ADD/SUB are never blocked by it.
    assign in_ready = w_adv && !(op_uses_acc(w_op) && r_acc_busy);
    assign w_accept = in_valid && in_ready;
    assign w_out_hs = r_stg[STAGES-1].ctl.valid && out_ready;

    // Operand formation; a refused or absent op enters as an all-zero bubble.
    always_comb begin
        w_opnd = '0;
        if (w_accept) begin
            w_opnd.ctl.valid = 1'b1;
            w_opnd.ctl.op    = w_op;
            case (w_op)
                OP_ADD: begin
                    w_opnd.a         = in_a;
                    w_opnd.b         = in_b;
                    w_opnd.ctl.carry = in_cin;
                end
                OP_SUB: begin
                    w_opnd.a         = in_a;
                    w_opnd.b         = ~in_b;
                    w_opnd.ctl.carry = 1'b1;
                end
                OP_ACC: begin
                    w_opnd.a         = in_a;
                    w_opnd.b         = r_acc;
                    w_opnd.ctl.carry = in_cin;
                end
                default: begin
                    // CLR: zero operands and zero carry give sum 0, cout 0, ovf 0.
                end
            endcase
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t        w_in;
        stage_t        w_out;
        logic [SW-1:0] w_ssum;

        if (k == 0) begin : g_src_in
            assign w_in = w_opnd;
        end else begin : g_src_reg
            assign w_in = r_stg[k-1];
        end

        for (genvar j = 0; j < BPS; j++) begin : g_blk
            logic w_ci;
            logic w_co;

            if (j == 0) begin : g_first
                assign w_ci = w_in.ctl.carry;
            end else begin : g_chain
                assign w_ci = g_blk[j-1].w_co;
            end

            carryskip_block #(
                .BLOCK (BLOCK)
            ) u_blk (
                .i_a    (w_in.a[k*SW + j*BLOCK +: BLOCK]),
                .i_b    (w_in.b[k*SW + j*BLOCK +: BLOCK]),
                .i_cin  (w_ci),
                .o_sum  (w_ssum[j*BLOCK +: BLOCK]),
                .o_cout (w_co)
            );
        end

        always_comb begin
            w_out                  = w_in;
            w_out.sum[k*SW +: SW]  = w_ssum;
            w_out.ctl.carry        = g_blk[BPS-1].w_co;
            // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
            if (k == STAGES - 1) begin
                w_out.ctl.msb_cin = w_ssum[SW-1] ^ w_in.a[WIDTH-1] ^ w_in.b[WIDTH-1];
            end
        end

        assign w_nxt[k] = w_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_stg[k] <= '0;
            end
            r_acc      <= '0;
            r_acc_busy <= 1'b0;
        end else begin
            if (w_adv) begin
                for (int k = 0; k < STAGES; k++) begin
                    r_stg[k] <= w_nxt[k];
                end
            end
            // Retire the pending accumulator op. A new ACC/CLR cannot be accepted
            // in this same cycle because in_ready sees the old busy flag.
            if (w_out_hs && op_uses_acc(r_stg[STAGES-1].ctl.op)) begin
                r_acc_busy <= 1'b0;
                r_acc      <= (r_stg[STAGES-1].ctl.op == OP_ACC) ? r_stg[STAGES-1].sum : '0;
            end
            if (w_accept && op_uses_acc(w_op)) begin
                r_acc_busy <= 1'b1;
            end
        end
    end

    assign out_valid = r_stg[STAGES-1].ctl.valid;
    assign out_sum   = r_stg[STAGES-1].sum;
    assign out_cout  = r_stg[STAGES-1].ctl.carry;
    assign out_ovf   = r_stg[STAGES-1].ctl.msb_cin ^ r_stg[STAGES-1].ctl.carry;
    assign out_zero  = r_stg[STAGES-1].ctl.valid && (r_stg[STAGES-1].sum == '0);

endmodule

// File: tb/tb_carryskip_pipe_addacc.sv
// tb/tb_carryskip_pipe_addacc.sv - directed self-checking bench for carryskip_pipe_addacc
module tb_carryskip_pipe_addacc;
    import carryskip_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        out_zero;

    int n_tests;
    int n_fail;

    carryskip_pipe_addacc #(
        .WIDTH (16),
        .BLOCK (4),
        .BPS   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, output bit ok);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            ok = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [19:0] got;
        got = {out_valid, out_sum, out_cout, out_ovf, out_zero};
        n_tests++;
        if (got !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", got, 20'h0);
        end
    endtask

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    task automatic test_arith();
        vec_t        v [8];
        logic [19:0] got;
        logic [19:0] exp;
        bit          ok;
        v = '{
            '{OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1},
            '{OP_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0},
            '{OP_SUB, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0},
            '{OP_ADD, 16'h00FF, 16'hFF00, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1},
            '{OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0},
            '{OP_SUB, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1},
            '{OP_ADD, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0},
            '{OP_ADD, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1}
        };
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(v[i].op, v[i].a, v[i].b, v[i].cin, ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL arith_accept[%0d]: in_ready never rose", i);
            end
            #1;
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL arith_latency[%0d]: out_valid %b one cycle after accept, want 0", i, out_valid);
            end
            @(negedge clk);
            #1;
            got = {out_valid, out_sum, out_cout, out_ovf, out_zero};
            exp = {1'b1, v[i].sum, v[i].cout, v[i].ovf, v[i].zero};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL arith_result[%0d]: {valid,sum,cout,ovf,zero} got %h want %h", i, got, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int sent;
        int got;
        sent      = 0;
        got       = 0;
        in_op     = OP_ADD;
        in_cin    = 1'b0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            out_ready = (cyc >= 4);
            in_valid  = (sent < 4);
            in_a      = 16'(sent + 1);
            in_b      = 16'(sent + 1);
            #1;
            if (cyc == 2) begin
                n_tests++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_full: in_ready %b out_valid %b, want 0 and 1", in_ready, out_valid);
                end
            end
            if (out_valid && !out_ready) begin
                n_tests++;
                if (out_sum !== 16'h0002) begin
                    n_fail++;
                    $display("FAIL bp_hold: out_sum %h while stalled, want 0002", out_sum);
                end
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (out_sum !== 16'(2 * (got + 1))) begin
                    n_fail++;
                    $display("FAIL bp_order[%0d]: out_sum %h want %h", got, out_sum, 16'(2 * (got + 1)));
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_tests++;
        if (got != 4 || sent != 4) begin
            n_fail++;
            $display("FAIL bp_count: sent %0d received %0d, want 4 and 4", sent, got);
        end
    endtask

    task automatic test_acc();
        logic [1:0]  ops   [4];
        logic [15:0] a_v   [4];
        logic [15:0] b_v   [4];
        logic [15:0] exp_s [4];
        int          acc_cyc [4];
        int          hs_cyc  [4];
        int          sent;
        int          got;
        ops   = '{OP_CLR, OP_ACC, OP_ADD, OP_ACC};
        a_v   = '{16'h1234, 16'h0010, 16'h0005, 16'h0020};
        b_v   = '{16'h5678, 16'hFFFF, 16'h0005, 16'hFFFF};
        exp_s = '{16'h0000, 16'h0010, 16'h000A, 16'h0030};
        acc_cyc = '{default: -100};
        hs_cyc  = '{default: -100};
        sent = 0;
        got  = 0;
        out_ready = 1'b1;
        in_cin    = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            in_valid = (sent < 4);
            if (sent < 4) begin
                in_op = ops[sent];
                in_a  = a_v[sent];
                in_b  = b_v[sent];
            end
            #1;
            if (out_valid) begin
                n_tests++;
                if (out_sum !== exp_s[got]) begin
                    n_fail++;
                    $display("FAIL acc_result[%0d]: out_sum %h want %h", got, out_sum, exp_s[got]);
                end
                if (got == 0) begin
                    n_tests++;
                    if ({out_cout, out_ovf, out_zero} !== 3'b001) begin
                        n_fail++;
                        $display("FAIL clr_flags: {cout,ovf,zero} %b want 001", {out_cout, out_ovf, out_zero});
                    end
                end
                hs_cyc[got] = cyc;
                got++;
            end
            if (in_valid && in_ready) begin
                acc_cyc[sent] = cyc;
                sent++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_tests++;
        if (got != 4) begin
            n_fail++;
            $display("FAIL acc_count: received %0d want 4", got);
        end
        n_tests++;
        if (acc_cyc[1] != hs_cyc[0] + 1) begin
            n_fail++;
            $display("FAIL acc_wait1: accepted cycle %0d want %0d", acc_cyc[1], hs_cyc[0] + 1);
        end
        n_tests++;
        if (acc_cyc[2] != acc_cyc[1] + 1) begin
            n_fail++;
            $display("FAIL add_not_stalled: accepted cycle %0d want %0d", acc_cyc[2], acc_cyc[1] + 1);
        end
        n_tests++;
        if (acc_cyc[3] != hs_cyc[1] + 1) begin
            n_fail++;
            $display("FAIL acc_wait2: accepted cycle %0d want %0d", acc_cyc[3], hs_cyc[1] + 1);
        end
    endtask

    task automatic test_reset_mid();
        bit ok1;
        bit ok2;
        out_ready = 1'b0;
        send(OP_ADD, 16'h0001, 16'h0002, 1'b0, ok1);
        send(OP_ADD, 16'h0003, 16'h0004, 1'b0, ok2);
        #1;
        n_tests++;
        if (!ok1 || !ok2 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_setup: accepted %b%b out_valid %b, want 11 and 1", ok1, ok2, out_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, out_sum, out_cout, out_ovf, out_zero} !== 20'h0) begin
            n_fail++;
            $display("FAIL rst_async: outputs %h without clock edge, want 0",
                     {out_valid, out_sum, out_cout, out_ovf, out_zero});
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        send(OP_ACC, 16'h0007, 16'h1234, 1'b0, ok1);
        n_tests++;
        if (!ok1) begin
            n_fail++;
            $display("FAIL rst_acc_accept: in_ready never rose");
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_sum !== 16'h0007) begin
            n_fail++;
            $display("FAIL rst_acc_result: valid %b sum %h want 1 and 0007", out_valid, out_sum);
        end
        @(negedge clk);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_arith();
        test_back_to_back();
        test_acc();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
